fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage in front of the decode/execute path. Reads the program counter from the register file's PC output (register 15), fetches one 32-bit instruction word over a simple hold-until-ack read bus, and presents it downstream with a valid/ready handshake. Writes PC+4 back into register 15 through the register file's B write port. Supports flush/redirect and flags misaligned PCs.

## Interface
- No parameters; data/address width fixed at 32, PC register index fixed at 4'd15.
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_pc  in  32  current PC, wired to register file o_reg_pc
- o_bus_addr  out  32  fetch address
- o_bus_rd  out  1  read request, held until i_bus_ack
- i_bus_data  in  32  read data, valid when i_bus_ack=1
- i_bus_ack  in  1  one-cycle read completion
- o_instr  out  32  fetched instruction word
- o_instr_valid  out  1  o_instr valid
- i_instr_ready  in  1  downstream accepts o_instr
- o_pc_wr  out  1  one-cycle PC write strobe (to regfile i_wr_b, with i_sel_b=15)
- o_pc_next  out  32  value written to PC (to regfile i_reg_b)
- i_flush  in  1  discard current fetch/instruction, restart from i_pc
- o_fault  out  1  sticky misaligned-PC fault

## Operation
- States: IDLE, FETCH, HOLD, DRAIN, FAULT.
- IDLE: entered on reset; all outputs 0; unconditionally to FETCH next cycle (lets the register file's synchronous reset clear the PC).
- FETCH: if i_pc[1:0]!=0 -> FAULT, no bus request issued. Else o_bus_rd=1, o_bus_addr=i_pc (registered when entering/at each cycle of FETCH; address must stay stable while o_bus_rd=1). On i_bus_ack: o_instr<=i_bus_data, o_instr_valid<=1, one-cycle o_pc_wr=1 with o_pc_next=o_bus_addr+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000) -> HOLD.
- HOLD: o_instr_valid=1, o_instr stable. On i_instr_ready=1 -> FETCH, valid drops next cycle.
- FAULT: o_fault=1, o_bus_rd=0, o_instr_valid=0; leaves only via i_flush (-> FETCH, o_fault cleared) or reset.
- i_flush (highest priority except reset), any state: no o_pc_wr that cycle, o_instr_valid cleared next cycle, ack data that cycle discarded.
  - FETCH with request outstanding and no ack this cycle -> DRAIN; ack same cycle -> FETCH.
  - IDLE/HOLD/FAULT -> FETCH.
- DRAIN: o_bus_rd held with unchanged address until i_bus_ack; data discarded; -> FETCH. Further i_flush in DRAIN has no extra effect.
- Unused-port rule: o_pc_next holds its last value when o_pc_wr=0.

## Timing
- Reset values: o_bus_rd=0, o_bus_addr=0, o_instr=0, o_instr_valid=0, o_pc_wr=0, o_pc_next=0, o_fault=0, state IDLE. Reset mid-bus-transaction abandons it; a later stray ack is ignored outside FETCH/DRAIN.
- Outputs are registered; no combinational path from i_bus_ack, i_instr_ready or i_flush to any output.
- o_bus_rd first asserted 1 cycle after entering FETCH at the earliest; with zero-wait ack (ack in first cycle of o_bus_rd=1), o_instr_valid rises the cycle after ack.
- o_pc_wr pulses in the same cycle o_instr_valid rises; i_pc reflects the new value one cycle later, before the next FETCH samples it (HOLD lasts >=1 cycle).
- Throughput: at most one instruction per 3 cycles (FETCH-req, ack, HOLD/handshake).
- i_bus_ack outside an outstanding request is ignored.

## Test plan
- Reset release, PC=0x00000000, memory word 0xDEADBEEF at 0, ack after 2 cycles, ready=1 -> o_bus_addr=0, o_instr=0xDEADBEEF valid one cycle, o_pc_wr pulse with o_pc_next=0x00000004, next fetch address 0x00000004.
- Backpressure: ready=0 for 5 cycles in HOLD -> o_instr/valid stable, no new o_bus_rd, single o_pc_wr pulse only.
- Flush with request outstanding (ack 3 cycles later) -> DRAIN keeps o_bus_rd and address, data discarded, no o_pc_wr, then refetch from new i_pc=0x00000100.
- Misaligned i_pc=0x00000102 -> o_fault=1, o_bus_rd never asserted; i_flush with i_pc=0x00000200 -> o_fault=0, fetch at 0x00000200.
- Wrap: i_pc=0xFFFFFFFC fetched -> o_pc_next=0x00000000.
- Async reset asserted mid-HOLD (between clock edges) -> o_instr_valid and o_bus_rd go 0 immediately; stray ack after release ignored, IDLE->FETCH sequence resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Reads the PC from register 15, fetches one word over a hold-until-ack read bus,
// presents it downstream with valid/ready, and writes PC+4 back via the B write port.
// Supports flush/redirect and latches a sticky fault on a misaligned PC.
module fetch_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_rd,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_ack,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic        o_pc_wr,
    output logic [31:0] o_pc_next,
    input  logic        i_flush,
    output logic        o_fault
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t          state_q;
    logic            bus_rd_q;
    logic [XLEN-1:0] bus_addr_q;
    logic [XLEN-1:0] instr_q;
    logic            instr_valid_q;
    logic            pc_wr_q;
    logic [XLEN-1:0] pc_next_q;
    logic            fault_q;

    // Request outstanding and completing this cycle; acks with no request are ignored.
    logic ack_taken_c;
    // Word alignment check on the incoming PC.
    logic pc_misaligned_c;
    // Address of the following sequential instruction (wraps mod 2^32).
    logic [XLEN-1:0] pc_inc_c;

    assign ack_taken_c     = bus_rd_q & i_bus_ack;
    assign pc_misaligned_c = (i_pc[1:0] != 2'b00);
    assign pc_inc_c        = bus_addr_q + PC_STEP;

    // Fetch control FSM; every output is a register updated here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            bus_rd_q      <= 1'b0;
            bus_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_wr_q       <= 1'b0;
            pc_next_q     <= '0;
            fault_q       <= 1'b0;
        end else begin
            // PC write strobe is a single-cycle pulse unless re-armed below.
            pc_wr_q <= 1'b0;

            if (i_flush) begin
                // Flush discards any instruction and any data arriving this cycle.
                instr_valid_q <= 1'b0;
                case (state_q)
                    S_FETCH: begin
                        if (bus_rd_q && !i_bus_ack) begin
                            // Bus cannot be abandoned; keep the request up and drain it.
                            state_q <= S_DRAIN;
                        end else begin
                            bus_rd_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        // Already draining: a further flush changes nothing.
                        if (i_bus_ack) begin
                            bus_rd_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end
                    end
                    default: begin
                        bus_rd_q <= 1'b0;
                        fault_q  <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                endcase
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // One idle cycle lets the register file clear the PC first.
                        bus_rd_q      <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (!bus_rd_q) begin
                            if (pc_misaligned_c) begin
                                fault_q <= 1'b1;
                                state_q <= S_FAULT;
                            end else begin
                                // Address latched once so it stays stable for the whole request.
                                bus_rd_q   <= 1'b1;
                                bus_addr_q <= i_pc;
                            end
                        end else if (ack_taken_c) begin
                            bus_rd_q      <= 1'b0;
                            instr_q       <= i_bus_data;
                            instr_valid_q <= 1'b1;
                            pc_wr_q       <= 1'b1;
                            pc_next_q     <= pc_inc_c;
                            state_q       <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (i_instr_ready) begin
                            instr_valid_q <= 1'b0;
                            state_q       <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (i_bus_ack) begin
                            bus_rd_q <= 1'b0;
                            state_q  <= S_FETCH;
                        end
                    end
                    S_FAULT: begin
                        // Parked until flush or reset.
                        bus_rd_q      <= 1'b0;
                        instr_valid_q <= 1'b0;
                        fault_q       <= 1'b1;
                    end
                    default: begin
                        bus_rd_q      <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_bus_addr    = bus_addr_q;
    assign o_bus_rd      = bus_rd_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = instr_valid_q;
    assign o_pc_wr       = pc_wr_q;
    assign o_pc_next     = pc_next_q;
    assign o_fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] bus_addr;
    logic        bus_rd;
    logic [31:0] bus_data;
    logic        bus_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_wr;
    logic [31:0] pc_next;
    logic        flush;
    logic        fault;

    int total;
    int bad;

    fetch_unit dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_pc         (pc),
        .o_bus_addr   (bus_addr),
        .o_bus_rd     (bus_rd),
        .i_bus_data   (bus_data),
        .i_bus_ack    (bus_ack),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .i_instr_ready(instr_ready),
        .o_pc_wr      (pc_wr),
        .o_pc_next    (pc_next),
        .i_flush      (flush),
        .o_fault      (fault)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        pc          = 32'h0;
        bus_data    = 32'h0;
        bus_ack     = 1'b0;
        instr_ready = 1'b0;
        flush       = 1'b0;

        // Reset values.
        step();
        check_eq("rst_rd",      32'(bus_rd), 32'd0);
        check_eq("rst_addr",    bus_addr, 32'h0);
        check_eq("rst_instr",   instr, 32'h0);
        check_eq("rst_valid",   32'(instr_valid), 32'd0);
        check_eq("rst_pcwr",    32'(pc_wr), 32'd0);
        check_eq("rst_pcnext",  pc_next, 32'h0);
        check_eq("rst_fault",   32'(fault), 32'd0);

        // Basic fetch from 0, ack two cycles into the request.
        rst = 1'b0;
        step();                                  // IDLE -> FETCH
        check_eq("idle_rd", 32'(bus_rd), 32'd0);
        step();                                  // FETCH issues request
        check_eq("f0_rd",   32'(bus_rd), 32'd1);
        check_eq("f0_addr", bus_addr, 32'h0);
        step();
        check_eq("f0_rd_wait", 32'(bus_rd), 32'd1);
        bus_data = 32'hDEADBEEF;
        bus_ack  = 1'b1;
        step();                                  // ack taken
        bus_ack = 1'b0;
        check_eq("f0_valid",  32'(instr_valid), 32'd1);
        check_eq("f0_instr",  instr, 32'hDEADBEEF);
        check_eq("f0_pcwr",   32'(pc_wr), 32'd1);
        check_eq("f0_pcnext", pc_next, 32'h4);
        check_eq("f0_rd_off", 32'(bus_rd), 32'd0);
        pc          = 32'h4;                     // regfile takes the write
        instr_ready = 1'b1;
        step();                                  // HOLD -> FETCH
        check_eq("f0_valid_drop", 32'(instr_valid), 32'd0);
        check_eq("f0_pcwr_drop",  32'(pc_wr), 32'd0);
        check_eq("f0_pcnext_hold", pc_next, 32'h4);
        step();
        check_eq("f1_rd",   32'(bus_rd), 32'd1);
        check_eq("f1_addr", bus_addr, 32'h4);

        // Backpressure: zero-wait ack, then ready low for five cycles.
        instr_ready = 1'b0;
        bus_data    = 32'h12345678;
        bus_ack     = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("bp_valid",  32'(instr_valid), 32'd1);
        check_eq("bp_pcnext", pc_next, 32'h8);
        check_eq("bp_pcwr",   32'(pc_wr), 32'd1);
        pc = 32'h8;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_hold_valid", 32'(instr_valid), 32'd1);
            check_eq("bp_hold_instr", instr, 32'h12345678);
            check_eq("bp_hold_rd",    32'(bus_rd), 32'd0);
            check_eq("bp_hold_pcwr",  32'(pc_wr), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        check_eq("bp_release", 32'(instr_valid), 32'd0);

        // Flush with a request outstanding: drain, then refetch from 0x100.
        step();
        check_eq("fl_rd",   32'(bus_rd), 32'd1);
        check_eq("fl_addr", bus_addr, 32'h8);
        flush = 1'b1;
        pc    = 32'h100;
        step();                                  // FETCH -> DRAIN
        flush = 1'b0;
        check_eq("dr_rd",    32'(bus_rd), 32'd1);
        check_eq("dr_addr",  bus_addr, 32'h8);
        check_eq("dr_valid", 32'(instr_valid), 32'd0);
        step();
        check_eq("dr_rd2",   32'(bus_rd), 32'd1);
        check_eq("dr_addr2", bus_addr, 32'h8);
        bus_data = 32'h00000BAD;
        bus_ack  = 1'b1;
        step();                                  // stale ack absorbed
        bus_ack = 1'b0;
        check_eq("dr_done_rd",    32'(bus_rd), 32'd0);
        check_eq("dr_done_pcwr",  32'(pc_wr), 32'd0);
        check_eq("dr_done_valid", 32'(instr_valid), 32'd0);
        check_eq("dr_done_instr", instr, 32'h12345678);
        step();
        check_eq("rf_rd",   32'(bus_rd), 32'd1);
        check_eq("rf_addr", bus_addr, 32'h100);
        bus_data = 32'hCAFEF00D;
        bus_ack  = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("rf_instr",  instr, 32'hCAFEF00D);
        check_eq("rf_pcnext", pc_next, 32'h104);
        pc = 32'h102;                            // misaligned next PC
        step();                                  // HOLD -> FETCH

        // Misaligned PC: sticky fault, no request; flush to 0x200 recovers.
        step();
        check_eq("mis_fault", 32'(fault), 32'd1);
        check_eq("mis_rd",    32'(bus_rd), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mis_hold_fault", 32'(fault), 32'd1);
            check_eq("mis_hold_rd",    32'(bus_rd), 32'd0);
            check_eq("mis_hold_valid", 32'(instr_valid), 32'd0);
        end
        flush = 1'b1;
        pc    = 32'h200;
        step();
        flush = 1'b0;
        check_eq("mis_clear", 32'(fault), 32'd0);
        step();
        check_eq("mis_rf_rd",   32'(bus_rd), 32'd1);
        check_eq("mis_rf_addr", bus_addr, 32'h200);
        bus_data = 32'h11111111;
        bus_ack  = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("mis_rf_pcnext", pc_next, 32'h204);
        pc = 32'hFFFFFFFC;
        step();                                  // HOLD -> FETCH

        // PC wrap at the top of the address space.
        step();
        check_eq("wr_addr", bus_addr, 32'hFFFFFFFC);
        instr_ready = 1'b0;
        bus_data    = 32'h22222222;
        bus_ack     = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("wr_pcwr",   32'(pc_wr), 32'd1);
        check_eq("wr_pcnext", pc_next, 32'h0);
        step();
        check_eq("wr_hold_valid", 32'(instr_valid), 32'd1);

        // Asynchronous reset between edges while in HOLD.
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_valid", 32'(instr_valid), 32'd0);
        check_eq("ar_rd",    32'(bus_rd), 32'd0);
        check_eq("ar_instr", instr, 32'h0);
        check_eq("ar_pcnext", pc_next, 32'h0);
        step();
        rst      = 1'b0;
        pc       = 32'h300;
        bus_data = 32'h33333333;
        bus_ack  = 1'b1;                         // stray ack while in IDLE
        step();
        bus_ack = 1'b0;
        check_eq("ar_stray_valid", 32'(instr_valid), 32'd0);
        check_eq("ar_stray_rd",    32'(bus_rd), 32'd0);
        check_eq("ar_stray_pcwr",  32'(pc_wr), 32'd0);
        step();
        check_eq("ar_resume_rd",    32'(bus_rd), 32'd1);
        check_eq("ar_resume_addr",  bus_addr, 32'h300);
        check_eq("ar_resume_valid", 32'(instr_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
